// File: rtl/breath_ramp_ctrl.sv
// Triangular duty-cycle envelope generator for the breathing-LED PWM stage.
// Advances only on PWM end-of-period strobes, so duty never changes mid-period.
module breath_ramp_ctrl #(
    parameter int DW               = 16,
    parameter int MAX_DUTY         = 30000,
    parameter int STEP             = 10,
    parameter int PERIODS_PER_STEP = 500,
    parameter int HOLD_PERIODS     = 250
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          period_end_i,
    output logic [DW-1:0] duty_o,
    output logic          duty_upd_o,
    output logic [1:0]    phase_o,
    output logic          cycle_done_o
);

    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HI   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LO   = 2'd3
    } phase_t;

    localparam bit            NO_HOLD = (HOLD_PERIODS == 0);
    localparam logic [15:0]   PPS_M1  = 16'(PERIODS_PER_STEP - 1);
    localparam logic [15:0]   HOLD_M1 = NO_HOLD ? 16'd0 : 16'(HOLD_PERIODS - 1);
    localparam logic [DW:0]   STEP_W  = (DW+1)'(STEP);
    localparam logic [DW:0]   MAX_W   = (DW+1)'(MAX_DUTY);
    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DUTY);

    phase_t        phase_q;
    logic [15:0]   pcnt_q;
    logic [DW-1:0] duty_q;
    logic          duty_upd_q;
    logic          cycle_done_q;

    logic          ev;
    logic [DW:0]   up_sum;
    logic [DW-1:0] duty_up_d;
    logic [DW-1:0] duty_dn_d;

    assign ev = period_end_i && en_i;

    // Step targets are computed one bit wider so neither direction can wrap.
    always_comb begin
        up_sum    = {1'b0, duty_q} + STEP_W;
        duty_up_d = (up_sum > MAX_W) ? MAX_D : up_sum[DW-1:0];
        duty_dn_d = ({1'b0, duty_q} >= STEP_W) ? (duty_q - STEP_W[DW-1:0]) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= RAMP_UP;
            pcnt_q       <= '0;
            duty_q       <= '0;
            duty_upd_q   <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            duty_upd_q   <= 1'b0;
            cycle_done_q <= 1'b0;
            if (ev) begin
                case (phase_q)
                    RAMP_UP: begin
                        if (pcnt_q < PPS_M1) begin
                            pcnt_q <= pcnt_q + 16'd1;
                        end else begin
                            pcnt_q     <= '0;
                            duty_q     <= duty_up_d;
                            duty_upd_q <= (duty_up_d != duty_q);
                            if (duty_up_d == MAX_D)
                                phase_q <= NO_HOLD ? RAMP_DOWN : HOLD_HI;
                        end
                    end
                    HOLD_HI: begin
                        if (pcnt_q < HOLD_M1) begin
                            pcnt_q <= pcnt_q + 16'd1;
                        end else begin
                            pcnt_q  <= '0;
                            phase_q <= RAMP_DOWN;
                        end
                    end
                    RAMP_DOWN: begin
                        if (pcnt_q < PPS_M1) begin
                            pcnt_q <= pcnt_q + 16'd1;
                        end else begin
                            pcnt_q     <= '0;
                            duty_q     <= duty_dn_d;
                            duty_upd_q <= (duty_dn_d != duty_q);
                            if (duty_dn_d == '0) begin
                                if (NO_HOLD) begin
                                    phase_q      <= RAMP_UP;
                                    cycle_done_q <= 1'b1;
                                end else begin
                                    phase_q <= HOLD_LO;
                                end
                            end
                        end
                    end
                    HOLD_LO: begin
                        if (pcnt_q < HOLD_M1) begin
                            pcnt_q <= pcnt_q + 16'd1;
                        end else begin
                            pcnt_q       <= '0;
                            phase_q      <= RAMP_UP;
                            cycle_done_q <= 1'b1;
                        end
                    end
                    default: begin
                        pcnt_q  <= '0;
                        phase_q <= RAMP_UP;
                    end
                endcase
            end
        end
    end

    assign duty_o       = duty_q;
    assign duty_upd_o   = duty_upd_q;
    assign phase_o      = phase_q;
    assign cycle_done_o = cycle_done_q;

endmodule
